// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_pkg
// Brief    : Shared store-size encodings, store FSM states and alignment rule.
// Revision : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

   localparam logic [1:0] c_SIZE_BYTE = 2'b00;
   localparam logic [1:0] c_SIZE_HALF = 2'b01;
   localparam logic [1:0] c_SIZE_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } store_state_t;

   // Both 2'b10 and 2'b11 encode a word access.
   function automatic logic store_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         c_SIZE_BYTE: store_aligned = 1'b1;
         c_SIZE_HALF: store_aligned = ~addr_lo[0];
         default:     store_aligned = (addr_lo == 2'b00);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_store_formatter.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_store_formatter
// Brief    : Replicates store data across byte lanes and builds the write mask.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_store_formatter
   import msrv32_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rs2,
   output logic [31:0] o_data,
   output logic [3:0]  o_mask
);

   always_comb begin
      o_data = i_rs2;
      o_mask = 4'b1111;
      case (i_size)
         c_SIZE_BYTE: begin
            o_data = {4{i_rs2[7:0]}};
            o_mask = 4'b0001 << i_addr_lo;
         end
         c_SIZE_HALF: begin
            o_data = {2{i_rs2[15:0]}};
            o_mask = 4'b0011 << {i_addr_lo[1], 1'b0};
         end
         c_SIZE_WORD, 2'b11: begin
            o_data = i_rs2;
            o_mask = 4'b1111;
         end
         default: begin
            o_data = i_rs2;
            o_mask = 4'b1111;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/msrv32_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_store_unit
// Brief    : Store path to the data bus: alignment check, lane formatting,
//            IDLE/BUSY handshake with bus-error and timeout reporting.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_store_unit
   import msrv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        mem_wr_req_in,
   input  logic [1:0]  store_size_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   input  logic        ahb_ready_in,
   input  logic        ahb_resp_in,
   output logic [31:0] ms_riscv32_mp_dmaddr_out,
   output logic [31:0] ms_riscv32_mp_dmdata_out,
   output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
   output logic        ms_riscv32_mp_dmwr_req_out,
   output logic        stall_out,
   output logic        misaligned_store_out,
   output logic        store_err_out
);

   localparam int unsigned        c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   store_state_t       r_state, w_state_nxt;
   logic [c_CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic [31:0]        r_addr, w_addr_nxt;
   logic [31:0]        r_data, w_data_nxt;
   logic [3:0]         r_mask, w_mask_nxt;
   logic               r_wr_req, w_wr_req_nxt;
   logic               r_misaligned, w_misaligned_nxt;
   logic               r_store_err, w_store_err_nxt;
   logic [31:0]        w_fmt_data;
   logic [3:0]         w_fmt_mask;
   logic               w_aligned;

   msrv32_store_formatter u_formatter (
      .i_size    (store_size_in),
      .i_addr_lo (iadder_in[1:0]),
      .i_rs2     (rs2_in),
      .o_data    (w_fmt_data),
      .o_mask    (w_fmt_mask)
   );

   assign w_aligned = store_aligned(store_size_in, iadder_in[1:0]);

   always_comb begin
      w_state_nxt      = r_state;
      w_wait_cnt_nxt   = r_wait_cnt;
      w_addr_nxt       = r_addr;
      w_data_nxt       = r_data;
      w_mask_nxt       = r_mask;
      w_wr_req_nxt     = r_wr_req;
      w_misaligned_nxt = 1'b0;
      w_store_err_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mem_wr_req_in) begin
               if (w_aligned) begin
                  w_state_nxt    = ST_BUSY;
                  w_wait_cnt_nxt = '0;
                  w_addr_nxt     = {iadder_in[31:2], 2'b00};
                  w_data_nxt     = w_fmt_data;
                  w_mask_nxt     = w_fmt_mask;
                  w_wr_req_nxt   = 1'b1;
               end else begin
                  w_misaligned_nxt = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            // Completion takes priority over a timeout landing on the same cycle.
            if (ahb_ready_in) begin
               w_state_nxt     = ST_IDLE;
               w_wr_req_nxt    = 1'b0;
               w_mask_nxt      = 4'b0000;
               w_store_err_nxt = ahb_resp_in;
            end else if (r_wait_cnt == c_CNT_LAST) begin
               w_state_nxt     = ST_IDLE;
               w_wr_req_nxt    = 1'b0;
               w_mask_nxt      = 4'b0000;
               w_store_err_nxt = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         r_state      <= ST_IDLE;
         r_wait_cnt   <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_mask       <= '0;
         r_wr_req     <= 1'b0;
         r_misaligned <= 1'b0;
         r_store_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wait_cnt   <= w_wait_cnt_nxt;
         r_addr       <= w_addr_nxt;
         r_data       <= w_data_nxt;
         r_mask       <= w_mask_nxt;
         r_wr_req     <= w_wr_req_nxt;
         r_misaligned <= w_misaligned_nxt;
         r_store_err  <= w_store_err_nxt;
      end
   end

   assign ms_riscv32_mp_dmaddr_out    = r_addr;
   assign ms_riscv32_mp_dmdata_out    = r_data;
   assign ms_riscv32_mp_dmwr_mask_out = r_mask;
   assign ms_riscv32_mp_dmwr_req_out  = r_wr_req;
   assign stall_out                   = (r_state == ST_BUSY);
   assign misaligned_store_out        = r_misaligned;
   assign store_err_out               = r_store_err;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_store_unit
// Brief    : Self-checking bench for msrv32_store_unit against a lane model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msrv32_store_unit;

   localparam int TO = 15;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic [1:0]  size  = 2'b00;
   logic [31:0] addr  = '0;
   logic [31:0] rs2   = '0;
   logic        rdy   = 1'b0;
   logic        resp  = 1'b0;
   logic [31:0] dmaddr, dmdata;
   logic [3:0]  mask;
   logic        wr_req, stall, misal, err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   msrv32_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .ms_riscv32_mp_clk_in        (clk),
      .ms_riscv32_mp_rst_in        (rst_n),
      .mem_wr_req_in               (req),
      .store_size_in               (size),
      .iadder_in                   (addr),
      .rs2_in                      (rs2),
      .ahb_ready_in                (rdy),
      .ahb_resp_in                 (resp),
      .ms_riscv32_mp_dmaddr_out    (dmaddr),
      .ms_riscv32_mp_dmdata_out    (dmdata),
      .ms_riscv32_mp_dmwr_mask_out (mask),
      .ms_riscv32_mp_dmwr_req_out  (wr_req),
      .stall_out                   (stall),
      .misaligned_store_out        (misal),
      .store_err_out               (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: access width in bytes drives alignment, lane and replication.
   function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] r,
                                     output bit ok, output logic [31:0] ea, output logic [31:0] ed,
                                     output logic [3:0] em);
      int unsigned nb;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ok = (a % nb) == 0;
      ea = a - (a % 4);
      if (nb == 1) begin
         ed = (r & 32'hFF) * 32'h0101_0101;
         em = 4'(1 << (a % 4));
      end else if (nb == 2) begin
         ed = (r & 32'hFFFF) * 32'h0001_0001;
         em = 4'(3 << (a % 4));
      end else begin
         ed = r;
         em = 4'hF;
      end
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"},  dmaddr, 32'h0);
      check({tag, "_data"},  dmdata, 32'h0);
      check({tag, "_mask"},  32'(mask), 32'h0);
      check({tag, "_req"},   32'(wr_req), 32'h0);
      check({tag, "_stall"}, 32'(stall), 32'h0);
      check({tag, "_misal"}, 32'(misal), 32'h0);
      check({tag, "_err"},   32'(err), 32'h0);
   endtask

   // Called at a negedge; delay = ready-less BUSY cycles before ready (>= TO never readies).
   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input int delay, input bit rsp, input bit b2b);
      bit          ok, timed_out;
      logic [31:0] ea, ed;
      logic [3:0]  em;
      int          len, exp_len;
      ref_store(sz, a, d, ok, ea, ed, em);
      req = 1'b1; size = sz; addr = a; rs2 = d; rdy = 1'b0; resp = 1'b0;
      @(negedge clk);
      req = 1'b0;
      if (!ok) begin
         check("misal_pulse", 32'(misal), 32'h1);
         check("misal_req",   32'(wr_req), 32'h0);
         check("misal_stall", 32'(stall), 32'h0);
         check("misal_mask",  32'(mask), 32'h0);
         @(negedge clk);
         check("misal_drop",  32'(misal), 32'h0);
         check("misal_idle",  32'(stall), 32'h0);
         return;
      end
      check("acc_misal", 32'(misal), 32'h0);
      check("acc_err",   32'(err), 32'h0);
      timed_out = (delay >= TO);
      exp_len   = timed_out ? TO : delay + 1;
      len = 0;
      while (1) begin
         check("busy_req",  32'(wr_req), 32'h1);
         check("busy_addr", dmaddr, ea);
         check("busy_data", dmdata, ed);
         check("busy_mask", 32'(mask), 32'(em));
         check("busy_err",  32'(err), 32'h0);
         len++;
         rdy  = (len - 1 == delay);
         resp = rdy ? rsp : 1'($urandom);
         req  = 1'($urandom);
         size = 2'($urandom);
         addr = $urandom;
         rs2  = $urandom;
         @(negedge clk);
         rdy = 1'b0; resp = 1'b0; req = 1'b0;
         if (stall !== 1'b1 || len >= TO + 5) break;
      end
      check("busy_len",  32'(len), 32'(exp_len));
      check("done_req",  32'(wr_req), 32'h0);
      check("done_mask", 32'(mask), 32'h0);
      check("done_stall", 32'(stall), 32'h0);
      check("done_err",  32'(err), timed_out ? 32'h1 : 32'(rsp));
      if (!b2b) begin
         rdy  = 1'($urandom);
         resp = 1'($urandom);
         @(negedge clk);
         rdy = 1'b0; resp = 1'b0;
         check("idle_err",   32'(err), 32'h0);
         check("idle_stall", 32'(stall), 32'h0);
         check("idle_req",   32'(wr_req), 32'h0);
         check("idle_mask",  32'(mask), 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      #2;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset_hold");
      rst_n = 1'b1;

      store(2'd0, 32'h0000_1003, 32'h0000_00A5, 2, 1'b0, 1'b0);
      store(2'd1, 32'h0000_2002, 32'h1234_BEEF, 0, 1'b0, 1'b0);
      store(2'd2, 32'h0000_3001, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      store(2'd2, 32'h0000_4000, 32'hCAFE_F00D, 1, 1'b1, 1'b0);
      store(2'd2, 32'h0000_5000, 32'h0BAD_0BAD, 100, 1'b0, 1'b0);
      store(2'd3, 32'h0000_6004, 32'h1111_2222, 0, 1'b0, 1'b1);
      store(2'd0, 32'h0000_6001, 32'h3333_4477, 1, 1'b0, 1'b0);

      // Reset in the middle of a transfer, released straight into a new request.
      req = 1'b1; size = 2'd2; addr = 32'h0000_7000; rs2 = 32'h7777_7777;
      @(negedge clk);
      req = 1'b0;
      check("rstbusy_req", 32'(wr_req), 32'h1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_async");
      @(negedge clk);
      check_all_zero("rst_held");
      rst_n = 1'b1;
      store(2'd1, 32'h0000_7002, 32'h55AA_1234, 1, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         int          dl;
         sz = 2'($urandom);
         a  = $urandom;
         if ($urandom_range(3) != 0)
            a = (sz == 2'd0) ? a : (sz == 2'd1) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
         dl = ($urandom_range(9) == 0) ? TO + int'($urandom_range(2)) : int'($urandom_range(3));
         store(sz, a, $urandom, dl, 1'($urandom), 1'($urandom));
      end
      @(negedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
